// File: rtl/decoder_pkg.sv
// Shared types for the sequenced one-hot decoder: FSM state encoding and mode values.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_divider.sv
// Step-pulse generator: one pulse every DIV_MAX cycles while not cleared.
module scan_divider #(
  parameter int unsigned DIV_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic step_c
);

  localparam int unsigned CNT_W = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_MAX - 1);

  logic [CNT_W-1:0] div_cnt;

  // The step fires on the last count of each period; a clear suppresses it.
  assign step_c = !clr && (div_cnt == LAST);

  // Period counter, held at zero while cleared so every run starts a full period.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/decoder_seq.sv
// Registered binary-to-one-hot decoder with handshaked DIRECT mode and auto-stepping SCAN mode.
// Optional build macro DECODER_SEQ_BOUNCE_EN: SCAN ping-pongs between the ends instead of wrapping.
module decoder_seq
  import decoder_pkg::*;
#(
  parameter  int unsigned SEL_W   = 3,
  parameter  int unsigned DIV_MAX = 4,
  localparam int unsigned OUT_W   = 1 << SEL_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic             mode,
  input  logic             sel_valid,
  input  logic [SEL_W-1:0] sel,
  output logic             sel_ready,
  output logic [OUT_W-1:0] out,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_W - 1);

  state_t           state;
  logic             scan_run;
  logic             step;
  logic [SEL_W-1:0] scan_idx;
  logic             scan_wrap;
`ifdef DECODER_SEQ_BOUNCE_EN
  logic             dir;
  logic             scan_dir;
`endif

  // Only DIRECT accepts a select; independent of sel_valid.
  assign sel_ready = (state == DIRECT);
  assign scan_run  = (state == SCAN) && en;

  scan_divider #(
    .DIV_MAX (DIV_MAX)
  ) u_scan_divider (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .clr    (!scan_run),
    .step_c (step)
  );

  // Next scan position and end-of-sweep flag for the coming step.
`ifdef DECODER_SEQ_BOUNCE_EN
  always_comb begin
    scan_idx = idx;
    scan_dir = dir;
    if (!dir) begin
      if (idx == IDX_LAST) begin
        scan_dir = 1'b1;
        scan_idx = SEL_W'(OUT_W - 2);
      end else begin
        scan_idx = idx + SEL_W'(1);
      end
    end else begin
      if (idx == '0) begin
        scan_dir = 1'b0;
        scan_idx = SEL_W'(1);
      end else begin
        scan_idx = idx - SEL_W'(1);
      end
    end
    scan_wrap = (scan_idx == '0) || (scan_idx == IDX_LAST);
  end
`else
  always_comb begin
    scan_idx  = idx + SEL_W'(1);
    scan_wrap = (scan_idx == '0);
  end
`endif

  // Mode FSM with registered index, one-hot output and wrap pulse.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      idx   <= '0;
      out   <= OUT_W'(1);
      wrap  <= 1'b0;
`ifdef DECODER_SEQ_BOUNCE_EN
      dir   <= 1'b0;
`endif
    end else begin
      wrap <= 1'b0;
      if (!en) begin
        state <= IDLE;
      end else begin
        state <= (mode == MODE_SCAN) ? SCAN : DIRECT;
        case (state)
          DIRECT: begin
            if (sel_valid) begin
              idx <= sel;
              out <= OUT_W'(1) << sel;
            end
          end
          SCAN: begin
            if (step) begin
              idx  <= scan_idx;
              out  <= OUT_W'(1) << scan_idx;
              wrap <= scan_wrap && (mode == MODE_SCAN);
`ifdef DECODER_SEQ_BOUNCE_EN
              dir  <= scan_dir;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decoder_seq.sv
// Bench for decoder_seq: directed vector table, multi-cycle scan/mode sequences,
// a DIV_MAX=1 instance, and randomized traffic against a behavioural model.
module tb_decoder_seq;

  localparam int unsigned SEL_W   = 3;
  localparam int unsigned DIV_MAX = 4;
  localparam int unsigned OUT_W   = 8;
`ifdef DECODER_SEQ_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
  localparam int PERIOD = 4 * (OUT_W - 1);
`else
  localparam bit BOUNCE = 1'b0;
  localparam int PERIOD = 4 * OUT_W;
`endif

  logic             sys_clk = 1'b0;
  logic             sys_rst, en, mode, sel_valid;
  logic [SEL_W-1:0] sel;
  logic             sel_ready, wrap;
  logic [OUT_W-1:0] out;
  logic [SEL_W-1:0] idx;

  logic             f_rst, f_en, f_mode, f_valid;
  logic [SEL_W-1:0] f_sel;
  logic             f_ready, f_wrap;
  logic [OUT_W-1:0] f_out;
  logic [SEL_W-1:0] f_idx;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 sys_clk = ~sys_clk;

  decoder_seq #(.SEL_W(SEL_W), .DIV_MAX(DIV_MAX)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .mode(mode),
    .sel_valid(sel_valid), .sel(sel), .sel_ready(sel_ready),
    .out(out), .idx(idx), .wrap(wrap)
  );

  decoder_seq #(.SEL_W(SEL_W), .DIV_MAX(1)) u_fast (
    .sys_clk(sys_clk), .sys_rst(f_rst), .en(f_en), .mode(f_mode),
    .sel_valid(f_valid), .sel(f_sel), .sel_ready(f_ready),
    .out(f_out), .idx(f_idx), .wrap(f_wrap)
  );

  typedef struct {
    logic rst, en, mode, valid;
    logic [SEL_W-1:0] sel;
    int   exp_idx;
    logic exp_wrap, exp_ready;
  } vec_t;
  vec_t vecs[$];

  // Behavioural model state
  int m_state;  // 0 idle, 1 direct, 2 scan
  int m_idx, m_cyc;
  bit m_wrap, m_dir;

  function automatic void add(logic r, logic e, logic m, logic v, int s, int ei, logic ew, logic er);
    vec_t t;
    t.rst = r; t.en = e; t.mode = m; t.valid = v; t.sel = SEL_W'(s);
    t.exp_idx = ei; t.exp_wrap = ew; t.exp_ready = er;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string nm, input longint unsigned got, input longint unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input int ei, input logic ew, input logic er);
    chk({nm, "_idx"}, 64'(idx), 64'(ei));
    chk({nm, "_out"}, 64'(out), 64'(1) << ei);
    chk({nm, "_wrap"}, 64'(wrap), 64'(ew));
    chk({nm, "_ready"}, 64'(sel_ready), 64'(er));
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic m, input logic v, input logic [SEL_W-1:0] s);
    sys_rst = r; en = e; mode = m; sel_valid = v; sel = s;
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_edge();
    int ns;
    if (sys_rst) begin
      m_state = 0; m_idx = 0; m_cyc = 0; m_wrap = 0; m_dir = 0;
      return;
    end
    m_wrap = 0;
    if (m_state == 2 && en) begin
      m_cyc++;
      if (m_cyc % DIV_MAX == 0) begin
        if (BOUNCE) begin
          if (!m_dir) begin
            if (m_idx == OUT_W - 1) begin m_dir = 1; m_idx = OUT_W - 2; end
            else m_idx++;
          end else begin
            if (m_idx == 0) begin m_dir = 0; m_idx = 1; end
            else m_idx--;
          end
          m_wrap = mode && (m_idx == 0 || m_idx == OUT_W - 1);
        end else begin
          m_idx  = (m_idx + 1) % OUT_W;
          m_wrap = mode && (m_idx == 0);
        end
      end
    end else if (m_state == 1 && en && sel_valid) begin
      m_idx = int'(sel);
    end
    ns = !en ? 0 : (mode ? 2 : 1);
    if (ns == 2 && m_state != 2) m_cyc = 0;
    m_state = ns;
  endtask

  initial begin
    int n, i0, nxt;
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    f_rst = 1'b1; f_en = 1'b0; f_mode = 1'b1; f_valid = 1'b0; f_sel = '0;

    // Directed table: reset, DIRECT sweep/hold, en=0, flip-cycle transfer, scan from 6
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 3, 0, 0, 1);
    for (int k = 0; k < 8; k++) add(0, 1, 0, 1, k, k, 0, 1);
    add(0, 1, 0, 0, 5, 7, 0, 1);
    add(0, 0, 0, 1, 2, 7, 0, 0);
    add(0, 0, 0, 1, 2, 7, 0, 0);
    add(0, 1, 0, 0, 0, 7, 0, 1);
    add(0, 1, 0, 1, 2, 2, 0, 1);
    add(0, 1, 1, 1, 6, 6, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 1, 1, 1, int'($urandom_range(0, 7)), 6, 0, 0);
    add(0, 1, 1, 0, 0, 7, BOUNCE, 0);
    for (int k = 0; k < 3; k++) add(0, 1, 1, 1, int'($urandom_range(0, 7)), 7, 0, 0);
    add(0, 1, 1, 0, 0, BOUNCE ? 6 : 0, !BOUNCE, 0);
    add(0, 1, 1, 0, 0, BOUNCE ? 6 : 0, 0, 0);

    for (int v = 0; v < vecs.size(); v++) begin
      drive(vecs[v].rst, vecs[v].en, vecs[v].mode, vecs[v].valid, vecs[v].sel);
      cyc();
      chk_all($sformatf("vec%0d", v), vecs[v].exp_idx, vecs[v].exp_wrap, vecs[v].exp_ready);
    end

    // Scan period: distance between consecutive wrap pulses
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
    n = 0;
    while (wrap !== 1'b1 && n < 40) begin cyc(); n++; end
    chk("find_wrap", 64'(wrap), 64'(1));
    n = 0;
    do begin cyc(); n++; end while (wrap !== 1'b1 && n < 40);
    chk("scan_period", 64'(n), 64'(PERIOD));

    // Mid-count switch to DIRECT freezes idx; re-entry waits a full period
    i0 = int'(idx);
    nxt = BOUNCE ? ((i0 == 0) ? 1 : OUT_W - 2) : (i0 + 1) % OUT_W;
    cyc(); chk("wrap_single", 64'(wrap), 64'(0));
    cyc();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd5);
    cyc(); chk_all("to_direct", i0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin cyc(); chk_all("direct_frozen", i0, 1'b0, 1'b1); end
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
    cyc(); chk_all("reenter_scan", i0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin cyc(); chk("reenter_hold", 64'(idx), 64'(i0)); end
    cyc(); chk("reenter_step", 64'(idx), 64'(nxt));

    // Reset in the middle of a scan period
    cyc(); cyc();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd4);
    cyc(); chk_all("rst_mid_scan", 0, 1'b0, 1'b0);

    // DIV_MAX=1 instance steps every cycle
    f_rst = 1'b0; f_en = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      int p, q, ei;
      logic ew;
      cyc();
      p = k - 1;
      if (BOUNCE) begin
        q  = p % (2 * (OUT_W - 1));
        ei = (q <= OUT_W - 1) ? q : 2 * (OUT_W - 1) - q;
        ew = (p > 0) && (ei == 0 || ei == OUT_W - 1);
      end else begin
        ei = p % OUT_W;
        ew = (p > 0) && (ei == 0);
      end
      chk($sformatf("fast%0d_idx", k), 64'(f_idx), 64'(ei));
      chk($sformatf("fast%0d_wrap", k), 64'(f_wrap), 64'(ew));
      chk($sformatf("fast%0d_out", k), 64'(f_out), 64'(1) << ei);
    end

    // Randomized traffic against the behavioural model
    for (int it = 0; it < 800; it++) begin
      logic r, e, m, v;
      r = (it == 0) || ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 19) != 0);
      m = ($urandom_range(0, 23) == 0) ? !mode : mode;
      v = 1'($urandom_range(0, 1));
      drive(r, e, m, v, SEL_W'($urandom_range(0, OUT_W - 1)));
      if (it > 0) chk("rnd_ready", 64'(sel_ready), 64'(m_state == 1));
      model_edge();
      cyc();
      chk("rnd_idx", 64'(idx), 64'(m_idx));
      chk("rnd_out", 64'(out), 64'(1) << m_idx);
      chk("rnd_wrap", 64'(wrap), 64'(m_wrap));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder_seq.md
Name: decoder_seq

Overview:
- Parametrised, registered binary-to-one-hot decoder. It generalises the combinational 3-to-8 decoder to SEL_W inputs and 2**SEL_W outputs.
- Adds two sequential operating modes:
  - DIRECT: registered decode of a handshaked select.
  - SCAN: the one-hot output auto-steps at a divided rate, as an LED chaser or display-digit scanner.
- Sits between control logic (switches or an FSM) and LED or digit-enable lines.

Parameters:
- SEL_W, 3, select width. Legal range is 1..6.
- OUT_W, 2**SEL_W, output width. Localparam derived from SEL_W, not user-overridable.
- DIV_MAX, 4, scan step period in sys_clk cycles. Must be >= 1.

Ports:
- sys_clk, input, 1, single clock. All logic is on the rising edge.
- sys_rst, input, 1, reset. Synchronous, active-high.
- en, input, 1, block enable.
- mode, input, 1, operating mode: 0 = DIRECT, 1 = SCAN.
- sel_valid, input, 1, sel is valid this cycle.
- sel, input, SEL_W, binary index to decode.
- sel_ready, output, 1, block accepts sel this cycle.
- out, output, OUT_W, registered one-hot output.
- idx, output, SEL_W, registered binary index currently driven on out.
- wrap, output, 1, one-cycle pulse when the scan index wraps.

Behaviour:
- Reset (sys_rst=1 at a clock edge) sets:
  - state=IDLE, out=1 (bit 0 set), idx=0, div_cnt=0, wrap=0.
  - sel_ready=0 while in IDLE.
- Invariant: out == (1 << idx) on every cycle. out is never all-zero and never multi-hot.
- States: IDLE, DIRECT, SCAN.
  - IDLE -> DIRECT when en=1 and mode=0; IDLE -> SCAN when en=1 and mode=1.
  - DIRECT <-> SCAN follows mode while en=1. The transition takes effect the cycle after mode changes.
  - Any state -> IDLE when en=0. out and idx are held, div_cnt is cleared.
- sel_ready is combinational: 1 if and only if state==DIRECT. It does not depend on sel_valid.
- DIRECT mode:
  - Transfer occurs when sel_valid && sel_ready.
  - Latency is 1 cycle: idx<=sel and out<=1<<sel at that edge.
  - No transfer means out is held.
  - Back-to-back transfers are accepted every cycle.
- SCAN mode:
  - div_cnt counts 0..DIV_MAX-1.
  - On the cycle div_cnt==DIV_MAX-1: div_cnt<=0 and idx<=idx+1 (out follows).
  - Wrap-around: idx == OUT_W-1 steps to 0 and wrap=1 for exactly that one cycle, aligned with idx becoming 0.
  - DIV_MAX=1: idx steps every cycle.
  - sel and sel_valid are ignored.
- Mode changes:
  - Entering SCAN from DIRECT or IDLE starts with div_cnt=0 and continues from the current idx. The first step occurs DIV_MAX cycles after entry.
  - Leaving SCAN clears div_cnt. wrap is 0 in every state other than SCAN.
- Simultaneous events:
  - sys_rst overrides all inputs.
  - en=0 overrides mode and sel_valid.
  - In the cycle where mode flips 0 -> 1, a sel_valid transfer is still accepted, because the state is still DIRECT.
- Reset mid-scan or mid-transfer: the next cycle shows the reset values. No partial step.

Optional Feature:
- Macro: DECODER_SEQ_BOUNCE_EN.
- Defined:
  - SCAN ping-pongs using a direction register dir, reset 0 = up.
  - At idx==OUT_W-1 while going up: dir<=1 and idx<=OUT_W-2.
  - At idx==0 while going down: dir<=0 and idx<=1.
  - wrap pulses at each reversal.
  - SEL_W=1: idx alternates 0,1.
  - dir is held across DIRECT and IDLE.
- Undefined: no dir register; wrap-around scan exactly as in Behaviour.

Decomposition:
- Shared package decoder_pkg holds:
  - state enum typedef (IDLE/DIRECT/SCAN).
  - mode constants MODE_DIRECT=1'b0 and MODE_SCAN=1'b1.
- One sub-module: scan_divider, a parametrised DIV_MAX tick generator with a synchronous clear, producing a one-cycle step pulse.
- The one-hot decode stays inline as a shift.

Test Plan:
- Reset: sys_rst=1 for 2 cycles, then release -> out=8'b0000_0001, idx=0, wrap=0, sel_ready=0.
- DIRECT sweep: en=1, mode=0; drive sel=0..7 with sel_valid=1 on consecutive cycles -> out=8'b0000_0001..8'b1000_0000, each 1 cycle after its sel; sel_ready=1 throughout.
- DIRECT hold: sel_valid=0 with sel=5 -> out unchanged. en=0 -> sel_ready=0 and a sel_valid=1 is ignored.
- SCAN, DIV_MAX=4, starting from idx=6:
  - idx=7 after 4 cycles.
  - idx=0 with wrap=1 (one cycle) after 8 cycles.
  - Full period is 32 cycles.
- Mode and reset mid-operation:
  - Switch to DIRECT mid-count -> idx frozen and div_cnt cleared.
  - Re-enter SCAN -> first step after exactly 4 cycles.
  - sys_rst mid-scan -> out=1 the next cycle.
- DECODER_SEQ_BOUNCE_EN: SCAN with DIV_MAX=1 from idx=0 -> sequence 0..7,6..0,1, with wrap at idx=7 and at idx=0.
